m_divider: RTL and testbench

- Iterative radix-2 restoring divider for the M extension.
- Counterpart to the Dadda-tree multiplier: executes DIV, DIVU, REM and REMU over a start/done handshake, one quotient bit per cycle.
- Sits beside the multiplier in the execute stage. The pipeline stalls on busy_o and captures result_o on done_o.

---
 rtl/m_divider_if.sv | 22 ++
 rtl/m_divider.sv | 141 ++++++++++++++
 tb/tb_m_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/m_divider_if.sv
// Start/done handshake bundle between the execute stage and the iterative divider.
interface m_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/m_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve at accept without iterating.
module m_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  m_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, becomes the quotient as bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] spec_q, spec_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             special_q, special_d;

  logic             signed_op, a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_val;
  logic [WIDTH:0]   shifted, diff;

  assign signed_op = ~bus.op_i[0];
  assign a_neg     = signed_op & bus.a_i[WIDTH-1];
  assign b_neg     = signed_op & bus.b_i[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag     = b_neg ? -bus.b_i : bus.b_i;
  assign div_zero  = (bus.b_i == '0);
  assign ovf       = signed_op && (bus.a_i == MIN_NEG) && (bus.b_i == '1);
  assign spec_val  = div_zero ? (bus.op_i[1] ? bus.a_i : '1)
                              : (bus.op_i[1] ? '0 : bus.a_i);

  // The shifted partial remainder needs WIDTH+1 bits before the trial subtract.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // NOTE: every register, including datapath, clears on reset so nothing
  // from an aborted operation leaks into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first keeps this comb block latch-free.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o   = (state_q != IDLE);
    bus.done_o   = (state_q == DONE);
    bus.result_o = res_q;
  end

  always_comb begin
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    spec_d    = spec_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    if (state_q == IDLE && bus.start_i) begin
      op_d      = bus.op_i;
      dvd_d     = a_mag;
      dvs_d     = b_mag;
      rem_d     = '0;
      qneg_d    = a_neg ^ b_neg;
      rneg_d    = a_neg;
      special_d = div_zero | ovf;
      spec_d    = spec_val;
      cnt_d     = (div_zero | ovf) ? '0 : CW'(WIDTH);
    end else if (state_q == CALC) begin
      if (cnt_q != '0) begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
      end else if (special_q) begin
        res_d = spec_q;
      end else if (op_q[1]) begin
        res_d = rneg_q ? -rem_q : rem_q;
      end else begin
        res_d = qneg_q ? -dvd_q : dvd_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      spec_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      spec_q    <= spec_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
    end
  end

endmodule

// File: tb/tb_m_divider.sv
// Directed-vector bench for m_divider: latency, sign rules, special cases,
// handshake behaviour and asynchronous reset.
module tb_m_divider;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  m_divider_if #(.WIDTH(W)) dut_if ();

  m_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure edges from accept to done_o and check result.
  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    dut_if.start_i = 1'b1;
    dut_if.op_i    = op;
    dut_if.a_i     = a;
    dut_if.b_i     = b;
    @(posedge clk); #1;
    dut_if.start_i = 1'b0;
    check({tag, "_busy"}, W'(dut_if.busy_o), W'(1));
    n = 0;
    while (!dut_if.done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, W'(n), W'(exp_lat));
    check({tag, "_res"}, dut_if.result_o, exp);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, W'(dut_if.done_o), W'(0));
    check({tag, "_idle"}, W'(dut_if.busy_o), W'(0));
  endtask

  initial begin
    int n;
    int done_seen;
    int res_changed;

    rst = 1'b1;
    dut_if.start_i = 1'b0;
    dut_if.op_i    = '0;
    dut_if.a_i     = '0;
    dut_if.b_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(dut_if.busy_o), W'(0));
    check("rst_done", W'(dut_if.done_o), W'(0));
    check("rst_res", dut_if.result_o, W'(0));
    @(negedge clk) rst = 1'b0;

    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dut_if.done_o) done_seen++;
    end
    check("idle_no_done", W'(done_seen), W'(0));
    check("idle_res", dut_if.result_o, W'(0));

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    done_seen = 0;
    res_changed = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dut_if.done_o) done_seen++;
      if (dut_if.result_o !== 32'd2) res_changed++;
    end
    check("hold_no_done", W'(done_seen), W'(0));
    check("hold_res", W'(res_changed), W'(0));

    run("div_m7_2", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2", OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
    run("div_7_m2", OP_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33);
    run("rem_7_m2", OP_REM, 32'd7, -32'sd2, 32'd1, 33);
    run("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    run("divu_max_max", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    run("rem_m8_4", OP_REM, -32'sd8, 32'd4, 32'd0, 33);

    run("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_m5_0", OP_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB, 1);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // start_i held high: operands changed mid-CALC must not leak into the result
    @(negedge clk);
    dut_if.start_i = 1'b1;
    dut_if.op_i    = OP_DIVU;
    dut_if.a_i     = 32'd100;
    dut_if.b_i     = 32'd7;
    @(posedge clk); #1;
    check("hs_accept", W'(dut_if.busy_o), W'(1));
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      n++;
    end
    dut_if.a_i = 32'd50;
    dut_if.b_i = 32'd5;
    while (!dut_if.done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs_lat", W'(n), W'(33));
    check("hs_res", dut_if.result_o, 32'd14);
    @(posedge clk); #1;
    check("hs_done_fall", W'(dut_if.done_o), W'(0));
    check("hs_idle_gap", W'(dut_if.busy_o), W'(0));
    @(posedge clk); #1;
    check("hs_reaccept", W'(dut_if.busy_o), W'(1));
    dut_if.start_i = 1'b0;
    n = 0;
    while (!dut_if.done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs2_lat", W'(n), W'(33));
    check("hs2_res", dut_if.result_o, 32'd10);
    @(posedge clk); #1;
    check("hs2_done_fall", W'(dut_if.done_o), W'(0));

    // asynchronous reset between edges during iteration 10
    @(negedge clk);
    dut_if.start_i = 1'b1;
    dut_if.op_i    = OP_DIVU;
    dut_if.a_i     = 32'd1000;
    dut_if.b_i     = 32'd3;
    @(posedge clk); #1;
    dut_if.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", W'(dut_if.busy_o), W'(0));
    check("mid_rst_done", W'(dut_if.done_o), W'(0));
    check("mid_rst_res", dut_if.result_o, W'(0));
    @(negedge clk) rst = 1'b0;
    run("post_rst_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
